// File: rtl/regfile_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_sequencer
//
// Multi-cycle controller for the 16x16 register file. It accepts an
// instruction word over a valid/ready handshake and turns it into register
// file read and write cycles. For ALU opcodes it also runs an external ALU
// through a start/done handshake and writes the result back.
//
// Instruction word: {opcode[15:12], dst[11:8], srcA[7:4], srcB[3:0]}.
// LDI uses [7:0] as an 8-bit immediate.
//   0x0 NOP, 0x1-0xB ALU op, 0xC MOV, 0xD LDI, 0xE RDONLY, 0xF illegal
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   instr_valid/instr   instruction source (instr_ready back to the source)
//   rf_a, rf_b          register file read data (valid the cycle after a read)
//   rf_en, rf_rw        register file enable and read/write select
//   rf_aa, rf_ba, rf_da register file read A / read B / write addresses
//   rf_d                register file write data
//   op_a, op_b, alu_op  latched operands and opcode presented to the ALU
//   alu_start           one-cycle ALU start pulse
//   alu_done/alu_result ALU completion and result
//   busy                high whenever the sequencer is not idle
//   done, err           one-cycle completion pulse, err flags illegal/timeout
// -----------------------------------------------------------------------------
module regfile_sequencer #(
   parameter int unsigned ALU_TIMEOUT = 15,
   parameter int unsigned DATA_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   input  logic [DATA_W-1:0] rf_a,
   input  logic [DATA_W-1:0] rf_b,
   output logic              rf_en,
   output logic              rf_rw,
   output logic [3:0]        rf_aa,
   output logic [3:0]        rf_ba,
   output logic [3:0]        rf_da,
   output logic [DATA_W-1:0] rf_d,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [3:0]        alu_op,
   output logic              alu_start,
   input  logic              alu_done,
   input  logic [DATA_W-1:0] alu_result,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_RDWAIT   = 3'd2,
      ST_EXEC     = 3'd3,
      ST_WAIT_ALU = 3'd4,
      ST_WRITE    = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   localparam logic [3:0] OPC_NOP = 4'h0;
   localparam logic [3:0] OPC_MOV = 4'hC;
   localparam logic [3:0] OPC_LDI = 4'hD;
   localparam logic [3:0] OPC_ILL = 4'hF;
   localparam logic [7:0] TIMEOUT_C = 8'(ALU_TIMEOUT);

   state_t     state_r;
   logic [3:0] opc_r;
   logic [3:0] dst_r;
   logic [7:0] cnt_r;
   logic       en_r;
   logic       rw_r;

   function automatic logic is_alu_op(input logic [3:0] opc);
      return (opc != 4'h0) && (opc <= 4'hB);
   endfunction

   // The register file must see EN (read only) while the system is in reset
   // so it clears alongside the sequencer; the handshake is closed during reset.
   assign rf_en       = rst | en_r;
   assign rf_rw       = rw_r & ~rst;
   assign instr_ready = (state_r == ST_IDLE) & ~rst;

   // Sequencer FSM with all datapath and handshake outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         opc_r     <= 4'h0;
         dst_r     <= 4'h0;
         cnt_r     <= 8'd0;
         en_r      <= 1'b0;
         rw_r      <= 1'b0;
         rf_aa     <= 4'h0;
         rf_ba     <= 4'h0;
         rf_da     <= 4'h0;
         rf_d      <= '0;
         op_a      <= '0;
         op_b      <= '0;
         alu_op    <= 4'h0;
         alu_start <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         // Pulsed outputs fall back to zero unless the branch below sets them.
         en_r      <= 1'b0;
         rw_r      <= 1'b0;
         alu_start <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (instr_valid) begin
                  opc_r <= instr[15:12];
                  dst_r <= instr[11:8];
                  busy  <= 1'b1;
                  case (instr[15:12])
                     OPC_NOP: begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                     end
                     OPC_ILL: begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                     end
                     OPC_LDI: begin
                        // No read needed: the immediate goes straight to the write.
                        state_r <= ST_WRITE;
                        en_r    <= 1'b1;
                        rw_r    <= 1'b1;
                        rf_da   <= instr[11:8];
                        rf_d    <= {{(DATA_W-8){1'b0}}, instr[7:0]};
                     end
                     default: begin
                        state_r <= ST_READ;
                        en_r    <= 1'b1;
                        rf_aa   <= instr[7:4];
                        rf_ba   <= instr[3:0];
                     end
                  endcase
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_READ: begin
               state_r <= ST_RDWAIT;
            end
            ST_RDWAIT: begin
               // Operands are captured here, before any write, so dst may alias a source.
               op_a <= rf_a;
               op_b <= rf_b;
               if (is_alu_op(opc_r)) begin
                  state_r   <= ST_EXEC;
                  alu_start <= 1'b1;
                  alu_op    <= opc_r;
               end else if (opc_r == OPC_MOV) begin
                  state_r <= ST_WRITE;
                  en_r    <= 1'b1;
                  rw_r    <= 1'b1;
                  rf_da   <= dst_r;
                  rf_d    <= rf_a;
               end else begin
                  state_r <= ST_DONE;
                  done    <= 1'b1;
               end
            end
            ST_EXEC: begin
               state_r <= ST_WAIT_ALU;
               cnt_r   <= 8'd0;
            end
            ST_WAIT_ALU: begin
               if (alu_done) begin
                  state_r <= ST_WRITE;
                  en_r    <= 1'b1;
                  rw_r    <= 1'b1;
                  rf_da   <= dst_r;
                  rf_d    <= alu_result;
               end else if ((cnt_r + 8'd1) == TIMEOUT_C) begin
                  // Abort after ALU_TIMEOUT silent cycles; nothing is written.
                  state_r <= ST_DONE;
                  done    <= 1'b1;
                  err     <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            ST_WRITE: begin
               state_r <= ST_DONE;
               done    <= 1'b1;
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [15:0] rf_a, rf_b;
   logic        rf_en, rf_rw;
   logic [3:0]  rf_aa, rf_ba, rf_da;
   logic [15:0] rf_d, op_a, op_b;
   logic [3:0]  alu_op;
   logic        alu_start;
   logic        alu_done;
   logic [15:0] alu_result;
   logic        busy, done, err;

   always #5 clk = ~clk;

   regfile_sequencer #(.ALU_TIMEOUT(15), .DATA_W(16)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .rf_a(rf_a), .rf_b(rf_b), .rf_en(rf_en),
      .rf_rw(rf_rw), .rf_aa(rf_aa), .rf_ba(rf_ba), .rf_da(rf_da), .rf_d(rf_d),
      .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_done(alu_done), .alu_result(alu_result), .busy(busy), .done(done),
      .err(err)
   );

   // Register file model: clears when enabled during reset, read data one cycle later.
   logic [15:0] mem [16];
   always @(posedge clk) begin
      if (rst) begin
         if (rf_en) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
         end
         rf_a <= 16'h0000;
         rf_b <= 16'h0000;
      end else if (rf_en) begin
         rf_a <= mem[rf_aa];
         rf_b <= mem[rf_ba];
         if (rf_rw) mem[rf_da] <= rf_d;
      end
   end

   // ALU model: result is op_a+op_b, alu_done rises alu_delay cycles after start (0 = never).
   int         alu_delay;
   logic [7:0] alu_cnt;
   always @(posedge clk) begin
      if (rst) begin
         alu_cnt    <= 8'd0;
         alu_result <= 16'h0000;
      end else if (alu_start) begin
         alu_cnt    <= 8'(alu_delay);
         alu_result <= op_a + op_b;
      end else if (alu_cnt != 8'd0) begin
         alu_cnt <= alu_cnt - 8'd1;
      end
   end
   assign alu_done = (alu_cnt == 8'd1);

   typedef struct {
      logic        err;
      int          lat;
      int          nwr;
      logic [3:0]  da;
      logic [15:0] d;
      int          nen;
      int          nst;
      logic        chk_ops;
      logic [15:0] a;
      logic [15:0] b;
   } exp_t;

   exp_t sb_q[$];
   int checks = 0;
   int errors = 0;
   int accepts = 0;
   int exp_accepts = 0;
   int writes_total = 0;
   int dones_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic e, input int lat, input int nwr,
                               input logic [3:0] da, input logic [15:0] d,
                               input int nen, input int nst, input logic chk,
                               input logic [15:0] a, input logic [15:0] b);
      exp_t x;
      x.err = e; x.lat = lat; x.nwr = nwr; x.da = da; x.d = d;
      x.nen = nen; x.nst = nst; x.chk_ops = chk; x.a = a; x.b = b;
      return x;
   endfunction

   // Monitor: tracks each accepted instruction and scores it when done appears.
   initial begin
      int lat, nwr, nen, nst;
      logic active;
      logic [3:0] wda;
      logic [15:0] wd;
      exp_t e;
      active = 1'b0;
      lat = 0; nwr = 0; nen = 0; nst = 0; wda = 4'h0; wd = 16'h0000;
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 1'b0;
         end else begin
            if (active) begin
               lat++;
               if (rf_en) nen++;
               if (rf_en && rf_rw) begin nwr++; wda = rf_da; wd = rf_d; end
               if (alu_start) nst++;
            end
            if (rf_en && rf_rw) writes_total++;
            if (done) begin
               dones_total++;
               if (sb_q.size() == 0) begin
                  check("unexpected_done", 32'(done), 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("err", 32'(err), 32'(e.err));
                  check("latency", 32'(lat), 32'(e.lat));
                  check("write_count", 32'(nwr), 32'(e.nwr));
                  check("en_cycles", 32'(nen), 32'(e.nen));
                  check("alu_starts", 32'(nst), 32'(e.nst));
                  if (e.nwr > 0) begin
                     check("write_addr", 32'(wda), 32'(e.da));
                     check("write_data", 32'(wd), 32'(e.d));
                  end
                  if (e.chk_ops) begin
                     check("op_a", 32'(op_a), 32'(e.a));
                     check("op_b", 32'(op_b), 32'(e.b));
                  end
               end
               active = 1'b0;
            end
            if (instr_valid && instr_ready) begin
               active = 1'b1;
               lat = 0; nwr = 0; nen = 0; nst = 0;
               accepts++;
            end
         end
      end
   end

   // Present an instruction until it is accepted; caller is #1 after a rising edge.
   task automatic issue(input logic [15:0] ins, input logic hold);
      int n;
      instr = ins;
      instr_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!instr_ready && n < 50);
      check("accept_timeout", 32'(instr_ready), 32'd1);
      exp_accepts++;
      if (!hold) begin
         @(posedge clk); #1;
         instr_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input logic hold);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (hold) check("ready_while_busy", 32'(instr_ready), 32'd0);
      end while (!done && n < 60);
      check("done_timeout", 32'(done), 32'd1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic run(input logic [15:0] ins, input exp_t e, input logic hold);
      sb_q.push_back(e);
      issue(ins, hold);
      wait_done(hold);
   endtask

   initial begin
      int w0, d0;
      rst = 1'b1;
      instr_valid = 1'b0;
      instr = 16'h0000;
      alu_delay = 1;

      // Reset held for two edges: register file must see EN with RW low.
      @(negedge clk);
      check("rst_rf_en_0", 32'(rf_en), 32'd1);
      check("rst_rf_rw_0", 32'(rf_rw), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("rst_rf_en_1", 32'(rf_en), 32'd1);
      check("rst_rf_rw_1", 32'(rf_rw), 32'd0);
      check("rst_ready", 32'(instr_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", 32'(instr_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done_err", 32'({done, err, alu_start}), 32'd0);
      check("idle_rf_en_rw", 32'({rf_en, rf_rw}), 32'd0);
      check("idle_addrs", 32'({rf_aa, rf_ba, rf_da, alu_op}), 32'd0);
      check("idle_data", 32'({op_a, op_b}), 32'd0);
      check("idle_rf_d", 32'(rf_d), 32'd0);
      @(posedge clk); #1;

      // r3 and r0 read back as zero after the register file reset.
      run(16'hE030, mk(1'b0, 3, 0, 4'h0, 16'h0000, 1, 0, 1'b1, 16'h0000, 16'h0000), 1'b0);
      run(16'hD5A7, mk(1'b0, 2, 1, 4'h5, 16'h00A7, 1, 0, 1'b0, 16'h0000, 16'h0000), 1'b0);
      run(16'hD112, mk(1'b0, 2, 1, 4'h1, 16'h0012, 1, 0, 1'b0, 16'h0000, 16'h0000), 1'b0);
      run(16'hD234, mk(1'b0, 2, 1, 4'h2, 16'h0034, 1, 0, 1'b0, 16'h0000, 16'h0000), 1'b0);
      // ADD r3 = r1 + r2, ALU answers one cycle after start.
      run(16'h1312, mk(1'b0, 6, 1, 4'h3, 16'h0046, 2, 1, 1'b1, 16'h0012, 16'h0034), 1'b0);
      run(16'hE035, mk(1'b0, 3, 0, 4'h0, 16'h0000, 1, 0, 1'b1, 16'h0046, 16'h00A7), 1'b0);
      // Silent ALU: 15 WAIT_ALU cycles then done+err, no write.
      alu_delay = 0;
      run(16'h1312, mk(1'b1, 19, 0, 4'h0, 16'h0000, 1, 1, 1'b1, 16'h0012, 16'h0034), 1'b0);
      // dst aliases srcA, ALU answers after 3 cycles: r1 = 0x12 + 0x46.
      alu_delay = 3;
      run(16'h3113, mk(1'b0, 8, 1, 4'h1, 16'h0058, 2, 1, 1'b1, 16'h0012, 16'h0046), 1'b0);
      run(16'hC520, mk(1'b0, 4, 1, 4'h5, 16'h0034, 2, 0, 1'b1, 16'h0034, 16'h0000), 1'b0);
      // Illegal opcode with instr_valid held through the busy period.
      run(16'hF000, mk(1'b1, 1, 0, 4'h0, 16'h0000, 0, 0, 1'b0, 16'h0000, 16'h0000), 1'b1);
      run(16'h0000, mk(1'b0, 1, 0, 4'h0, 16'h0000, 0, 0, 1'b0, 16'h0000, 16'h0000), 1'b0);

      // Reset while waiting on the ALU: no write, no done.
      alu_delay = 0;
      w0 = writes_total;
      d0 = dones_total;
      issue(16'h1312, 1'b0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(instr_ready), 32'd1);
      repeat (3) @(negedge clk);
      check("abort_no_write", 32'(writes_total), 32'(w0));
      check("abort_no_done", 32'(dones_total), 32'(d0));
      @(posedge clk); #1;

      alu_delay = 1;
      run(16'hD15A, mk(1'b0, 2, 1, 4'h1, 16'h005A, 1, 0, 1'b0, 16'h0000, 16'h0000), 1'b0);
      run(16'hC410, mk(1'b0, 4, 1, 4'h4, 16'h005A, 2, 0, 1'b1, 16'h005A, 16'h0000), 1'b0);
      run(16'hE043, mk(1'b0, 3, 0, 4'h0, 16'h0000, 1, 0, 1'b1, 16'h005A, 16'h0000), 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      check("accept_count", 32'(accepts), 32'(exp_accepts));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multi-cycle controller that drives the 16x16 register file.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them into register file read/write cycles (AA/BA/DA/RW/EN/D).
- Sequences an external ALU through a start/done handshake and writes results back.
- Sits between the instruction source and the register file/ALU pair.

Parameters:
ALU_TIMEOUT, 15, max cycles spent in WAIT_ALU before aborting with err (1..255)
DATA_W, 16, datapath width; must match register file word width

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  reset, synchronous, active-high
instr_valid  in  1  instruction word present
instr  in  16  {opcode[15:12], dst[11:8], srcA[7:4], srcB[3:0]}; LDI uses [7:0] as imm8
instr_ready  out  1  sequencer can accept an instruction
rf_a  in  16  register file A output (valid the cycle after a read edge)
rf_b  in  16  register file B output
rf_en  out  1  register file EN
rf_rw  out  1  register file RW (0 read, 1 read+write)
rf_aa  out  4  read address A
rf_ba  out  4  read address B
rf_da  out  4  write address
rf_d  out  16  write data
op_a  out  16  latched operand A to ALU
op_b  out  16  latched operand B to ALU
alu_op  out  4  opcode forwarded to ALU
alu_start  out  1  one-cycle ALU start pulse
alu_done  in  1  ALU result valid (sampled only in WAIT_ALU)
alu_result  in  16  ALU result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse coincident with done on illegal opcode or ALU timeout

Behaviour:
- Reset (rst=1 at clk edge): state to IDLE; op_a, op_b, rf_d, rf_aa, rf_ba, rf_da, alu_op all 0; alu_start, done, err, busy, instr_ready 0.
- While rst=1: rf_en=1 and rf_rw=0, so the register file sees EN during its own reset and clears.
- Reset mid-operation aborts immediately. No writeback is issued and no done pulse is generated.
- Handshake: instr_ready=1 only in IDLE with rst=0. The transfer occurs on an edge with instr_valid && instr_ready; the instruction is latched at that edge. instr_valid outside IDLE is ignored; no buffering.
- Opcode classes:
  - 0x0 NOP: no register file access.
  - 0x1-0xB: ALU op.
  - 0xC MOV: dst <= srcA.
  - 0xD LDI: dst <= {8'b0, imm8}.
  - 0xE RDONLY: reads srcA/srcB into op_a/op_b, no write.
  - 0xF: illegal.
- States: IDLE, READ, RDWAIT, EXEC, WAIT_ALU, WRITE, DONE.
- IDLE -> on accept:
  - NOP -> DONE
  - 0xF -> DONE (err)
  - LDI -> WRITE
  - all others -> READ
- READ: rf_en=1, rf_rw=0, rf_aa=srcA, rf_ba=srcB. Next state RDWAIT.
- RDWAIT: rf_en=0; op_a<=rf_a, op_b<=rf_b at exit edge.
  - ALU op -> EXEC
  - MOV -> WRITE
  - RDONLY -> DONE
- EXEC: alu_start=1 for exactly one cycle; alu_op=opcode. Next state WAIT_ALU; the timeout counter clears.
- WAIT_ALU:
  - alu_done=1: latch alu_result into rf_d, go to WRITE.
  - Otherwise increment the counter. When the counter reaches ALU_TIMEOUT without alu_done, go to DONE with err, no write.
- WRITE: rf_en=1, rf_rw=1, rf_da=dst, rf_d held, rf_aa/rf_ba unchanged. Exactly one cycle. Next state DONE.
  - rf_d source: ALU result, op_a (MOV), or zero-extended imm8 (LDI).
- DONE: done=1 (err=1 if illegal or timeout) for one cycle. Next state IDLE. instr_ready returns to 1 the following cycle.
- rf_en=0 in every state other than READ and WRITE (rst excepted). The sequencer never asserts write outside WRITE.
- Latency, accept edge to done cycle (done high in the Nth cycle after the accept edge):
  - NOP/illegal: 1
  - LDI: 2
  - RDONLY: 3
  - MOV: 4
  - ALU: 5+k, where k = WAIT_ALU cycles before alu_done (min k=1 → 6)
- srcA==dst or srcB==dst is legal. Operands are latched before the write, so there is no hazard.
- Counter width 8 bits. ALU_TIMEOUT=0 is illegal.

Test Plan:
- Reset with rst=1 for 2 cycles → rf_en=1, rf_rw=0 during reset; after release instr_ready=1, all other outputs 0; LDI to r3 then RDONLY r3 → op_a=0x0000 before LDI effect confirms clear.
- LDI instr=0xD5A7 → WRITE cycle with rf_da=5, rf_d=0x00A7, rf_rw=1; done 2 cycles after accept; err=0.
- After LDI r1=0x12, LDI r2=0x34: ADD instr=0x1312 with ALU returning 0x0046 and alu_done one cycle after alu_start → single alu_start pulse, op_a=0x0012, op_b=0x0034, write r3=0x0046, done 6 cycles after accept.
- Same ADD with alu_done never asserted, ALU_TIMEOUT=15 → done and err pulse together after 15 WAIT_ALU cycles; no cycle with rf_rw=1.
- instr=0xF000 → done+err 1 cycle after accept, rf_en stays 0; instr_valid held high during busy → no second accept until IDLE.
- Assert rst during WAIT_ALU → next cycle IDLE, no done, no write; MOV instr=0xC410 afterward copies r1 to r4 normally.
